kmeans_iter_ctrl: RTL and testbench

Top-level sequencer for the k-means classification datapath. Loads the initial centroids from the core and streams points from RAM through the distance/classify pipes. It then steps the divider/centroid-update pass via cent_cnt and decides per iteration between re-classifying and finishing. It drives all enables of the pipe1 stage: centroid_en, first_iteration, input_reg_en and cent_cnt.

---
 rtl/kmeans_pkg.sv | 22 ++
 rtl/ctrl_delay_line.sv | 27 ++
 rtl/kmeans_iter_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_kmeans_iter_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared types and helpers for the k-means iteration controller.
package kmeans_pkg;

  // Width of a centroid index (8 centroid registers).
  localparam int CENT_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLASSIFY,
    DRAIN,
    UPDATE,
    CHECK,
    FIN
  } ctrl_state_t;

  // One-hot decode of a centroid index into a per-register write enable.
  function automatic logic [7:0] onehot8(input logic [CENT_IDX_W-1:0] idx);
    onehot8 = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
// Used to align control strobes with the datapath pipeline stages.
module ctrl_delay_line #(
  parameter int DEPTH = 1,  // number of register stages, must be >= 1
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the input through DEPTH stages; reset clears every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// Top-level sequencer for the k-means classification datapath:
// centroid load, point streaming, centroid update pass and the
// per-iteration convergence decision.
// Optional build macro KMEANS_ITER_LIMIT_EN adds an iteration limit
// (MAX_ITER) and the o_limit_hit flag.
module kmeans_iter_ctrl
  import kmeans_pkg::*;
#(
  parameter int addrWidth    = 8,
  parameter int centroid_num = 8,   // fixed by the 3-bit centroid index
  parameter int PIPE_LAT     = 2,   // input_reg_en -> accum_en latency, >= 1
  parameter int MAX_ITER     = 16,
  parameter int iter_width   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [addrWidth-1:0]    i_num_points_m1,
  input  logic [CENT_IDX_W-1:0]   i_k_m1,
  input  logic                    i_cent_in_valid,
  output logic                    o_cent_in_ready,
  input  logic                    i_converged,
  output logic                    o_ram_rd_en,
  output logic [addrWidth-1:0]    o_ram_addr,
  output logic                    o_input_reg_en,
  output logic                    o_first_iteration,
  output logic [centroid_num-1:0] o_centroid_en,
  output logic [CENT_IDX_W-1:0]   o_cent_cnt,
  output logic                    o_accum_clr,
  output logic                    o_accum_en,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [iter_width-1:0]   o_iter_count
`ifdef KMEANS_ITER_LIMIT_EN
  ,
  output logic                    o_limit_hit
`endif
);

  localparam int DRAIN_W = $clog2(PIPE_LAT + 2);

  ctrl_state_t r_state, w_state_next;

  logic [addrWidth-1:0]    r_np_m1;
  logic [CENT_IDX_W-1:0]   r_k_m1;
  logic [CENT_IDX_W-1:0]   r_load_idx;
  logic [addrWidth-1:0]    r_addr;
  logic [DRAIN_W-1:0]      r_drain_cnt;
  logic [3:0]              r_upd_cnt;
  logic [CENT_IDX_W-1:0]   r_cent_cnt;
  logic [iter_width-1:0]   r_iter_count;
  logic                    r_accum_clr;
`ifdef KMEANS_ITER_LIMIT_EN
  logic                    r_limit_hit;
`endif

  logic                    w_ram_rd_en;
  logic                    w_cent_in_ready;
  logic                    w_first_iteration;
  logic [centroid_num-1:0] w_centroid_en;
  logic                    w_done;
  logic                    w_load_last;
  logic                    w_addr_last;
  logic                    w_drain_last;
  logic                    w_upd_last;
  logic                    w_upd_valid;
  logic                    w_upd_valid_2d;
  logic [CENT_IDX_W-1:0]   w_cent_cnt_2d;
  logic [iter_width-1:0]   w_iter_inc;
  logic                    w_fin;

  assign w_load_last  = (r_load_idx == r_k_m1);
  assign w_addr_last  = (r_addr == r_np_m1);
  assign w_drain_last = (r_drain_cnt == DRAIN_W'(PIPE_LAT));
  // UPDATE lasts k_m1+3 cycles so the 2-cycle-late write of index k_m1 lands inside it.
  assign w_upd_last   = (r_upd_cnt == ({1'b0, r_k_m1} + 4'd2));
  // Only the first k_m1+1 UPDATE cycles carry a fresh index into the divider.
  assign w_upd_valid  = (r_state == UPDATE) && (r_upd_cnt <= {1'b0, r_k_m1});
  // Iteration counter saturates instead of wrapping.
  assign w_iter_inc   = (&r_iter_count) ? r_iter_count : r_iter_count + 1'b1;

`ifdef KMEANS_ITER_LIMIT_EN
  assign w_fin = i_converged || (w_iter_inc == iter_width'(MAX_ITER));
`else
  assign w_fin = i_converged;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and combinational control outputs.
  always_comb begin
    w_state_next      = r_state;
    w_ram_rd_en       = 1'b0;
    w_cent_in_ready   = 1'b0;
    w_first_iteration = 1'b0;
    w_centroid_en     = '0;
    w_done            = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_next = LOAD;
      end
      LOAD: begin
        w_first_iteration = 1'b1;
        w_cent_in_ready   = 1'b1;
        if (i_cent_in_valid) begin
          w_centroid_en = onehot8(r_load_idx);
          if (w_load_last) w_state_next = CLASSIFY;
        end
      end
      CLASSIFY: begin
        w_ram_rd_en = 1'b1;
        if (w_addr_last) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_drain_last) w_state_next = UPDATE;
      end
      UPDATE: begin
        if (w_upd_valid_2d) w_centroid_en = onehot8(w_cent_cnt_2d);
        if (w_upd_last) w_state_next = CHECK;
      end
      CHECK: begin
        w_state_next = w_fin ? FIN : CLASSIFY;
      end
      FIN: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Per-state counters, latched run parameters and the accum_clr pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_np_m1      <= '0;
      r_k_m1       <= '0;
      r_load_idx   <= '0;
      r_addr       <= '0;
      r_drain_cnt  <= '0;
      r_upd_cnt    <= '0;
      r_cent_cnt   <= '0;
      r_iter_count <= '0;
      r_accum_clr  <= 1'b0;
`ifdef KMEANS_ITER_LIMIT_EN
      r_limit_hit  <= 1'b0;
`endif
    end else begin
      r_accum_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_np_m1      <= i_num_points_m1;
            r_k_m1       <= i_k_m1;
            r_load_idx   <= '0;
            r_iter_count <= '0;
`ifdef KMEANS_ITER_LIMIT_EN
            r_limit_hit  <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (i_cent_in_valid) begin
            if (w_load_last) begin
              r_load_idx  <= '0;
              r_accum_clr <= 1'b1;
            end else begin
              r_load_idx <= r_load_idx + 1'b1;
            end
          end
        end
        CLASSIFY: begin
          // Compare before incrementing so a full-range run never wraps early.
          if (w_addr_last) r_addr <= '0;
          else             r_addr <= r_addr + 1'b1;
        end
        DRAIN: begin
          if (w_drain_last) r_drain_cnt <= '0;
          else              r_drain_cnt <= r_drain_cnt + 1'b1;
        end
        UPDATE: begin
          if (w_upd_last) begin
            r_upd_cnt  <= '0;
            r_cent_cnt <= '0;
          end else begin
            r_upd_cnt <= r_upd_cnt + 1'b1;
            if (r_cent_cnt != r_k_m1) r_cent_cnt <= r_cent_cnt + 1'b1;
          end
        end
        CHECK: begin
          r_iter_count <= w_iter_inc;
          if (!w_fin) r_accum_clr <= 1'b1;
`ifdef KMEANS_ITER_LIMIT_EN
          if (!i_converged && (w_iter_inc == iter_width'(MAX_ITER))) r_limit_hit <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // RAM read latency: pipe1 input register loads one cycle after the read.
  ctrl_delay_line #(.DEPTH(1), .WIDTH(1)) u_ire_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_ram_rd_en),
    .o_q   (o_input_reg_en)
  );

  // Distance/classify pipe latency up to the accumulators.
  ctrl_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(1)) u_acc_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (o_input_reg_en),
    .o_q   (o_accum_en)
  );

  // Divider latency: the new centroid for cent_cnt appears two cycles later.
  ctrl_delay_line #(.DEPTH(2), .WIDTH(CENT_IDX_W)) u_cnt_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (r_cent_cnt),
    .o_q   (w_cent_cnt_2d)
  );

  ctrl_delay_line #(.DEPTH(2), .WIDTH(1)) u_vld_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_upd_valid),
    .o_q   (w_upd_valid_2d)
  );

  assign o_cent_in_ready   = w_cent_in_ready;
  assign o_ram_rd_en       = w_ram_rd_en;
  assign o_ram_addr        = r_addr;
  assign o_first_iteration = w_first_iteration;
  assign o_centroid_en     = w_centroid_en;
  assign o_cent_cnt        = r_cent_cnt;
  assign o_accum_clr       = r_accum_clr;
  assign o_busy            = (r_state != IDLE);
  assign o_done            = w_done;
  assign o_iter_count      = r_iter_count;
`ifdef KMEANS_ITER_LIMIT_EN
  assign o_limit_hit       = r_limit_hit;
`endif

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed self-checking bench for kmeans_iter_ctrl.
// Inputs change and outputs are checked just after the falling edge.
module tb_kmeans_iter_ctrl;

`ifdef KMEANS_ITER_LIMIT_EN
  localparam int TB_MAX_ITER = 2;
`else
  localparam int TB_MAX_ITER = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_points_m1 = '0;
  logic [2:0] k_m1 = '0;
  logic       cent_in_valid = 1'b0;
  logic       cent_in_ready;
  logic       converged = 1'b0;
  logic       ram_rd_en;
  logic [7:0] ram_addr;
  logic       input_reg_en;
  logic       first_iteration;
  logic [7:0] centroid_en;
  logic [2:0] cent_cnt;
  logic       accum_clr;
  logic       accum_en;
  logic       busy;
  logic       done;
  logic [4:0] iter_count;
`ifdef KMEANS_ITER_LIMIT_EN
  logic       limit_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kmeans_iter_ctrl #(
    .addrWidth    (8),
    .centroid_num (8),
    .PIPE_LAT     (2),
    .MAX_ITER     (TB_MAX_ITER),
    .iter_width   (5)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_start           (start),
    .i_num_points_m1   (num_points_m1),
    .i_k_m1            (k_m1),
    .i_cent_in_valid   (cent_in_valid),
    .o_cent_in_ready   (cent_in_ready),
    .i_converged       (converged),
    .o_ram_rd_en       (ram_rd_en),
    .o_ram_addr        (ram_addr),
    .o_input_reg_en    (input_reg_en),
    .o_first_iteration (first_iteration),
    .o_centroid_en     (centroid_en),
    .o_cent_cnt        (cent_cnt),
    .o_accum_clr       (accum_clr),
    .o_accum_en        (accum_en),
    .o_busy            (busy),
    .o_done            (done),
    .o_iter_count      (iter_count)
`ifdef KMEANS_ITER_LIMIT_EN
    ,
    .o_limit_hit       (limit_hit)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_slot();
    @(negedge clk);
    #1;
  endtask

  // From an IDLE slot: start a run and feed k+1 centroids, with an
  // optional one-cycle stall before beat stall_at. Ends on CLASSIFY slot 0.
  task automatic load_pass(input int np, input int k, input int stall_at);
    start         = 1'b1;
    num_points_m1 = 8'(np);
    k_m1          = 3'(k);
    cent_in_valid = 1'b1;
    check("idle_busy", busy, 0);
    next_slot();
    start = 1'b0;
    for (int i = 0; i <= k; i++) begin
      if (i == stall_at) begin
        cent_in_valid = 1'b0;
        #1;
        check("load_stall_en", centroid_en, 0);
        check("load_stall_rdy", cent_in_ready, 1);
        next_slot();
        cent_in_valid = 1'b1;
        #1;
      end
      check("load_rdy", cent_in_ready, 1);
      check("load_first", first_iteration, 1);
      check("load_en", centroid_en, 32'd1 << i);
      check("load_busy", busy, 1);
      next_slot();
    end
    cent_in_valid = 1'b0;
    $display("load np_m1=%0d k_m1=%0d stall_at=%0d", np, k, stall_at);
  endtask

  // From CLASSIFY slot 0: stream, drain, update and check one iteration.
  // Ends on the next CLASSIFY slot 0, or on an IDLE slot when finishing.
  task automatic iter_pass(input int np, input int k, input bit conv,
                           input int iter_before, input bit expect_fin);
    for (int s = 0; s <= np + 3; s++) begin
      check("cls_rd", ram_rd_en, (s <= np) ? 1 : 0);
      check("cls_addr", ram_addr, (s <= np) ? s : 0);
      check("cls_ire", input_reg_en, (s >= 1 && s <= np + 1) ? 1 : 0);
      check("cls_ae", accum_en, (s >= 3 && s <= np + 3) ? 1 : 0);
      check("cls_clr", accum_clr, (s == 0) ? 1 : 0);
      if (s == 0) begin
        check("cls_rdy", cent_in_ready, 0);
        check("cls_iter", iter_count, iter_before);
      end
      // A start pulse while busy must not disturb the run.
      start = (s == 1);
      if (s == 1) begin
        k_m1          = 3'(7 - k);
        num_points_m1 = 8'(np + 5);
      end
      next_slot();
    end
    for (int u = 0; u <= k + 2; u++) begin
      check("upd_cnt", cent_cnt, (u <= k) ? u : k);
      check("upd_en", centroid_en, (u >= 2) ? (32'd1 << (u - 2)) : 0);
      check("upd_first", first_iteration, 0);
      check("upd_ae", accum_en, 0);
      next_slot();
    end
    converged = conv;
    check("chk_cnt", cent_cnt, 0);
    check("chk_en", centroid_en, 0);
    check("chk_busy", busy, 1);
    check("chk_iter", iter_count, iter_before);
    next_slot();
    converged = 1'b0;
    check("post_iter", iter_count, iter_before + 1);
    if (expect_fin) begin
      check("fin_done", done, 1);
      check("fin_busy", busy, 1);
      next_slot();
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_iter", iter_count, iter_before + 1);
    end else begin
      check("again_done", done, 0);
    end
    $display("iteration %0d np_m1=%0d k_m1=%0d converged=%0d fin=%0d",
             iter_before + 1, np, k, conv, expect_fin);
  endtask

  // Every output must read zero (used after reset).
  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdy"}, cent_in_ready, 0);
    check({tag, "_rd"}, ram_rd_en, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_ire"}, input_reg_en, 0);
    check({tag, "_first"}, first_iteration, 0);
    check({tag, "_en"}, centroid_en, 0);
    check({tag, "_cnt"}, cent_cnt, 0);
    check({tag, "_clr"}, accum_clr, 0);
    check({tag, "_ae"}, accum_en, 0);
    check({tag, "_iter"}, iter_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (3) next_slot();
    check_all_zero("reset");
`ifdef KMEANS_ITER_LIMIT_EN
    check("reset_limit", limit_hit, 0);
`endif
    rst_n = 1'b1;
    next_slot();

    // Three iterations, converged on the third CHECK.
    load_pass(3, 2, -1);
    iter_pass(3, 2, 1'b0, 0, 1'b0);
    iter_pass(3, 2, 1'b0, 1, 1'b0);
    iter_pass(3, 2, 1'b1, 2, 1'b1);

    // Full update pass with all eight centroids, single point, load stall.
    load_pass(0, 7, 3);
    iter_pass(0, 7, 1'b1, 0, 1'b1);

    // Reset in the middle of UPDATE.
    load_pass(1, 1, -1);
    for (int s = 0; s <= 4; s++) next_slot();
    next_slot();
    check("pre_rst_cnt", cent_cnt, 1);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    next_slot();
    check_all_zero("mid_rst");
    rst_n = 1'b1;
    next_slot();
    $display("reset during UPDATE");

    // Single centroid, full address range after the reset.
    load_pass(255, 0, -1);
    iter_pass(255, 0, 1'b1, 0, 1'b1);

`ifdef KMEANS_ITER_LIMIT_EN
    // Iteration limit with converged held low.
    load_pass(1, 0, -1);
    iter_pass(1, 0, 1'b0, 0, 1'b0);
    iter_pass(1, 0, 1'b0, 1, 1'b1);
    check("limit_set", limit_hit, 1);
    load_pass(1, 0, -1);
    check("limit_clr", limit_hit, 0);
    iter_pass(1, 0, 1'b1, 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
